// File: rtl/mmio_fifo_bridge_if.sv
// mmio_fifo_bridge_if: core data-memory port plus accelerator TX/RX streams.
// The slave modport is the bridge's view of the bus and the master modport is the core/accelerator side.
interface mmio_fifo_bridge_if #(
  parameter int DATA_WIDTH = 64
);
  logic [9:0]            mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  irq;

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_re,
    input  m_ready, s_valid, s_data,
    output mem_rdata, m_valid, m_data,
    output s_ready, irq
  );

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_re,
    output m_ready, s_valid, s_data,
    input  mem_rdata, m_valid, m_data,
    input  s_ready, irq
  );
endinterface

// File: rtl/mmio_fifo_bridge.sv
// mmio_fifo_bridge: MMIO TX/RX FIFOs between the core and a stream accelerator.
// Optional TX_TOTAL/RX_TOTAL counters are enabled by defining MMIO_FIFO_STATS_EN.
module mmio_fifo_bridge #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 64
) (
  input logic               clk,
  input logic               reset_n,
  mmio_fifo_bridge_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t         tx_mem [FIFO_DEPTH];
  word_t         rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [PW-1:0] tx_cnt, rx_cnt;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          ie, tx_ovf, rx_unf;
  word_t         rdata_q, rd_val, status;

  logic       sel, wr, ld;
  logic [4:0] idx;
  logic       tx_push_req, tx_push, tx_pop;
  logic       rx_pop_req, rx_pop, rx_push;
  logic       ctrl_wr;
  logic       unused_addr;

  assign sel  = (bus.mem_addr[9:8] != 2'b00);
  assign idx  = bus.mem_addr[7:3];
  assign wr   = sel & bus.mem_we;
  assign ld   = sel & bus.mem_re;
  assign unused_addr = ^bus.mem_addr[2:0];

  assign tx_cnt   = tx_wp - tx_rp;
  assign rx_cnt   = rx_wp - rx_rp;
  assign tx_empty = (tx_wp == tx_rp);
  assign rx_empty = (rx_wp == rx_rp);
  assign tx_full  = (tx_cnt == PW'(FIFO_DEPTH));
  assign rx_full  = (rx_cnt == PW'(FIFO_DEPTH));

  // Full is judged before any same-cycle stream pop.
  assign tx_push_req = wr & (idx == 5'd0);
  assign tx_push     = tx_push_req & ~tx_full;
  assign tx_pop      = ~tx_empty & bus.m_ready;

  // A write in the same cycle wins, so the load pops nothing.
  assign rx_pop_req = ld & ~bus.mem_we & (idx == 5'd1);
  assign rx_pop     = rx_pop_req & ~rx_empty;
  assign rx_push    = bus.s_valid & ~rx_full;
  assign ctrl_wr    = wr & (idx == 5'd3);

  assign bus.m_valid = ~tx_empty;
  assign bus.m_data  = tx_empty ? '0 : tx_mem[tx_rp[AW-1:0]];
  assign bus.s_ready = ~rx_full;
  assign bus.irq     = ie & ~rx_empty;
  assign bus.mem_rdata = rdata_q;

`ifdef MMIO_FIFO_STATS_EN
  logic [31:0] tx_total, rx_total;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_total <= '0;
      rx_total <= '0;
    end else begin
      if (wr && idx == 5'd4) tx_total <= '0;
      else if (tx_pop)       tx_total <= tx_total + 32'd1;
      if (wr && idx == 5'd5) rx_total <= '0;
      else if (rx_push)      rx_total <= rx_total + 32'd1;
    end
  end
`endif

  always_comb begin
    status        = '0;
    status[0]     = tx_full;
    status[1]     = tx_empty;
    status[2]     = rx_full;
    status[3]     = rx_empty;
    status[15:8]  = 8'(tx_cnt);
    status[23:16] = 8'(rx_cnt);
    status[32]    = tx_ovf;
    status[33]    = rx_unf;
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      idx == 5'd1: rd_val = rx_pop ? rx_mem[rx_rp[AW-1:0]] : '0;
      idx == 5'd2: rd_val = status;
      idx == 5'd3: rd_val = DATA_WIDTH'(ie);
`ifdef MMIO_FIFO_STATS_EN
      idx == 5'd4: rd_val = DATA_WIDTH'(tx_total);
      idx == 5'd5: rd_val = DATA_WIDTH'(rx_total);
`endif
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= bus.mem_wdata;
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= bus.s_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_wp   <= '0;
      tx_rp   <= '0;
      rx_wp   <= '0;
      rx_rp   <= '0;
      ie      <= 1'b0;
      tx_ovf  <= 1'b0;
      rx_unf  <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (ctrl_wr) begin
        ie <= bus.mem_wdata[0];
        if (bus.mem_wdata[1]) begin
          tx_ovf <= 1'b0;
          rx_unf <= 1'b0;
        end
      end
      if (tx_push_req && tx_full) tx_ovf <= 1'b1;
      if (rx_pop_req && rx_empty) rx_unf <= 1'b1;
      if (ld)               rdata_q <= rd_val;
      else if (bus.mem_re)  rdata_q <= '0;
    end
  end
endmodule

// File: tb/tb_mmio_fifo_bridge.sv
// tb_mmio_fifo_bridge: directed checks of the MMIO FIFO bridge.
// Expected values are hand-computed for FIFO_DEPTH=8, DATA_WIDTH=64.
module tb_mmio_fifo_bridge;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mmio_fifo_bridge_if #(.DATA_WIDTH(64)) bus ();

  mmio_fifo_bridge #(
    .FIFO_DEPTH(8),
    .DATA_WIDTH(64)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [9:0] a,
                       input logic [63:0] d);
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_we    = 1'b1;
    tick();
    bus.mem_we    = 1'b0;
  endtask

  task automatic load(input logic [9:0] a,
                      output logic [63:0] d);
    bus.mem_addr = a;
    bus.mem_re   = 1'b1;
    tick();
    bus.mem_re   = 1'b0;
    d = bus.mem_rdata;
  endtask

  task automatic rx_push(input logic [63:0] d);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    tick();
    bus.s_valid = 1'b0;
  endtask

  logic [63:0] r;
  logic [63:0] q[$];
  logic [63:0] rx_exp [4];

  initial begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.m_ready   = 1'b0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    tick();
    tick();
    reset_n = 1'b1;

    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd1);
    chk("rst_irq", 64'(bus.irq), 64'd0);
    chk("rst_rdata", bus.mem_rdata, 64'd0);
    chk("rst_m_data", bus.m_data, 64'd0);
    load(10'h110, r);
    chk("rst_status", r, 64'h0A);

    // nine stores into an 8-deep TX FIFO
    for (int k = 1; k <= 9; k++) store(10'h100, 64'(k * 'h11));
    load(10'h110, r);
    chk("tx_full_status", r, 64'h1_0000_0809);
    bus.m_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("tx_drain_valid", 64'(bus.m_valid), 64'd1);
      chk("tx_drain_data", bus.m_data, 64'(k * 'h11));
      tick();
    end
    chk("tx_drained", 64'(bus.m_valid), 64'd0);
    bus.m_ready = 1'b0;

    // back-to-back RX pops, fourth one underflows
    rx_push(64'hA);
    rx_push(64'hB);
    rx_push(64'hC);
    rx_exp = '{64'hA, 64'hB, 64'hC, 64'h0};
    bus.mem_addr = 10'h108;
    bus.mem_re   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rx_b2b", bus.mem_rdata, rx_exp[i]);
    end
    bus.mem_re = 1'b0;
    load(10'h110, r);
    chk("rx_unf_status", r, 64'h3_0000_000A);

    // interrupt enable and sticky clear
    store(10'h118, 64'd1);
    rx_push(64'h55);
    chk("irq_set", 64'(bus.irq), 64'd1);
    load(10'h108, r);
    chk("irq_pop_data", r, 64'h55);
    chk("irq_clr", 64'(bus.irq), 64'd0);
    store(10'h118, 64'd3);
    load(10'h110, r);
    chk("sticky_clr", r, 64'h0A);
    load(10'h118, r);
    chk("ctrl_rd", r, 64'd1);
    load(10'h010, r);
    chk("sel_low_rd", r, 64'd0);
    load(10'h138, r);
    chk("unmapped_rd", r, 64'd0);

    // concurrent push/pop at count 3 across pointer wrap
    for (int i = 0; i < 3; i++) begin
      store(10'h100, 64'h100 + 64'(i));
      q.push_back(64'h100 + 64'(i));
    end
    load(10'h110, r);
    chk("tx_cnt3", r, 64'h30A & ~64'h2);
    bus.m_ready = 1'b1;
    for (int i = 3; i < 20; i++) begin
      chk("wrap_data", bus.m_data, q[0]);
      store(10'h100, 64'h100 + 64'(i));
      void'(q.pop_front());
      q.push_back(64'h100 + 64'(i));
    end
    bus.m_ready = 1'b0;
    load(10'h110, r);
    chk("tx_cnt_kept", r, 64'h308);
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("wrap_tail", bus.m_data, q[0]);
      void'(q.pop_front());
      tick();
    end
    chk("wrap_empty", 64'(bus.m_valid), 64'd0);
    bus.m_ready = 1'b0;

    // half-full FIFOs, then reset with a load in flight
    for (int i = 0; i < 4; i++) store(10'h100, 64'hE0 + 64'(i));
    for (int i = 0; i < 4; i++) rx_push(64'hF0 + 64'(i));
    load(10'h110, r);
    chk("half_status", r, 64'h04_0400);
`ifdef MMIO_FIFO_STATS_EN
    load(10'h120, r);
    chk("tx_total", r, 64'd28);
    load(10'h128, r);
    chk("rx_total", r, 64'd8);
`else
    load(10'h120, r);
    chk("tx_total_off", r, 64'd0);
    load(10'h128, r);
    chk("rx_total_off", r, 64'd0);
`endif
    bus.mem_addr = 10'h108;
    bus.mem_re   = 1'b1;
    reset_n      = 1'b0;
    tick();
    bus.mem_re   = 1'b0;
    reset_n      = 1'b1;
    chk("mrst_rdata", bus.mem_rdata, 64'd0);
    chk("mrst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("mrst_m_data", bus.m_data, 64'd0);
    chk("mrst_s_ready", 64'(bus.s_ready), 64'd1);
    load(10'h110, r);
    chk("mrst_status", r, 64'h0A);
    load(10'h120, r);
    chk("mrst_tx_total", r, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
